// File: rtl/truth_table_checker_if.sv
// Bus bundle between truth_table_checker and whoever drives it.
// master = stimulus/response side (bench, wrapper), slave = the checker.
// Optional FIRST_FAIL_EN adds the first-failure report signals.
interface truth_table_checker_if #(
   parameter int NUM_IN  = 4,
   parameter int NUM_OUT = 3
) ();
   localparam int ROWS = 1 << NUM_IN;

   logic                     start;
   logic [NUM_OUT*ROWS-1:0]  exp_mask;
   logic [NUM_IN-1:0]        vec_out;
   logic [NUM_OUT-1:0]       resp_in;
   logic                     busy;
   logic                     done;
   logic                     pass;
   logic [NUM_IN:0]          err_count;
   logic [NUM_OUT*ROWS-1:0]  cap_mask;
`ifdef FIRST_FAIL_EN
   logic [NUM_IN-1:0]        first_fail_row;
   logic [NUM_OUT-1:0]       first_fail_bits;

   modport master (
      output start, exp_mask, resp_in,
      input  vec_out, busy, done, pass, err_count, cap_mask,
             first_fail_row, first_fail_bits
   );

   modport slave (
      input  start, exp_mask, resp_in,
      output vec_out, busy, done, pass, err_count, cap_mask,
             first_fail_row, first_fail_bits
   );
`else
   modport master (
      output start, exp_mask, resp_in,
      input  vec_out, busy, done, pass, err_count, cap_mask
   );

   modport slave (
      input  start, exp_mask, resp_in,
      output vec_out, busy, done, pass, err_count, cap_mask
   );
`endif

endinterface

// File: rtl/truth_table_checker.sv
// truth_table_checker: sweeps all 2^NUM_IN input rows of a combinational
// block, samples its NUM_OUT outputs after SETTLE cycles per row, builds
// captured minterm masks and counts rows that differ from the expected masks.
// Optional feature macro: FIRST_FAIL_EN (first mismatching row and its
// XOR bits are latched and reported).
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start after reset
// SETTLE | vec_out held, settle counter running 0..SETTLE-1
// SAMPLE | one cycle: capture resp_in for this row, count a mismatch
// DONE   | result valid (done/pass/err_count/cap_mask), start restarts
module truth_table_checker #(
   parameter int NUM_IN  = 4,
   parameter int NUM_OUT = 3,
   parameter int SETTLE  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   truth_table_checker_if.slave     bus
);

   localparam int ROWS   = 1 << NUM_IN;
   localparam int MASK_W = NUM_OUT * ROWS;
   localparam int CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

   localparam logic [NUM_IN:0]  LAST_ROW    = (NUM_IN+1)'(ROWS - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE_S = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              r_state;
   logic [NUM_IN:0]     r_row;
   logic [CNT_W-1:0]    r_cnt;
   logic [NUM_IN-1:0]   r_vec_out;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic [NUM_IN:0]     r_err_count;
   logic [MASK_W-1:0]   r_cap_mask;
   logic [MASK_W-1:0]   r_exp_mask;
`ifdef FIRST_FAIL_EN
   logic                r_fail_seen;
   logic [NUM_IN-1:0]   r_first_fail_row;
   logic [NUM_OUT-1:0]  r_first_fail_bits;
`endif

   logic [NUM_IN-1:0]   w_row_idx;
   logic [NUM_OUT-1:0]  w_exp_bits;
   logic [NUM_OUT-1:0]  w_diff_bits;
   logic                w_row_err;
   logic [NUM_IN:0]     w_err_next;
   logic [MASK_W-1:0]   w_cap_next;

   // The row counter is one bit wider than needed; its top bit never sets
   // because termination is by compare against LAST_ROW.
   assign w_row_idx = r_row[NUM_IN-1:0];

   // Per output: pick this row's expected bit and form the updated capture field.
   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      logic [ROWS-1:0] w_exp_field;
      logic [ROWS-1:0] w_cap_field;

      assign w_exp_field   = r_exp_mask[g*ROWS +: ROWS];
      assign w_exp_bits[g] = w_exp_field[w_row_idx];

      // Overwrite only the bit of the current row in this output's mask.
      always_comb begin
         w_cap_field            = r_cap_mask[g*ROWS +: ROWS];
         w_cap_field[w_row_idx] = bus.resp_in[g];
      end

      assign w_cap_next[g*ROWS +: ROWS] = w_cap_field;
   end

   // A row counts once however many of its outputs differ.
   assign w_diff_bits = bus.resp_in ^ w_exp_bits;
   assign w_row_err   = |w_diff_bits;
   assign w_err_next  = r_err_count + {{NUM_IN{1'b0}}, w_row_err};

   // Sweep sequencer: all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_row       <= '0;
         r_cnt       <= '0;
         r_vec_out   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err_count <= '0;
         r_cap_mask  <= '0;
         r_exp_mask  <= '0;
`ifdef FIRST_FAIL_EN
         r_fail_seen       <= 1'b0;
         r_first_fail_row  <= '0;
         r_first_fail_bits <= '0;
`endif
      end else begin
         case (r_state)
            IDLE, DONE: begin
               // start is only looked at here, so a start while busy is dropped.
               if (bus.start) begin
                  r_exp_mask  <= bus.exp_mask;
                  r_row       <= '0;
                  r_cnt       <= '0;
                  r_vec_out   <= '0;
                  r_cap_mask  <= '0;
                  r_err_count <= '0;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= SETTLE_S;
`ifdef FIRST_FAIL_EN
                  r_fail_seen       <= 1'b0;
                  r_first_fail_row  <= '0;
                  r_first_fail_bits <= '0;
`endif
               end
            end

            SETTLE_S: begin
               if (r_cnt == SETTLE_LAST) begin
                  r_cnt   <= '0;
                  r_state <= SAMPLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            SAMPLE: begin
               r_cap_mask  <= w_cap_next;
               r_err_count <= w_err_next;
`ifdef FIRST_FAIL_EN
               if (w_row_err && !r_fail_seen) begin
                  r_fail_seen       <= 1'b1;
                  r_first_fail_row  <= w_row_idx;
                  r_first_fail_bits <= w_diff_bits;
               end
`endif
               if (r_row == LAST_ROW) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_next == '0);
                  r_state <= DONE;
               end else begin
                  // vec_out moves only here, so it is stable for the whole row.
                  r_row     <= r_row + (NUM_IN+1)'(1);
                  r_vec_out <= r_vec_out + NUM_IN'(1);
                  r_cnt     <= '0;
                  r_state   <= SETTLE_S;
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.vec_out   = r_vec_out;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.pass      = r_pass;
   assign bus.err_count = r_err_count;
   assign bus.cap_mask  = r_cap_mask;
`ifdef FIRST_FAIL_EN
   assign bus.first_fail_row  = r_first_fail_row;
   assign bus.first_fail_bits = r_first_fail_bits;
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker driving the breadboard block
// r1 = x | ~y&z, r2 = De Morgan form of r1, r3 = wxyz + w'x'y'z'.
module tb_truth_table_checker;

   localparam int NI   = 4;
   localparam int NO   = 3;
   localparam int ST   = 2;
   localparam int ROWS = 1 << NI;
   localparam int LAT  = ROWS * (ST + 1);

   localparam logic [47:0] MASK_OK = 48'h8001_F2F2_F2F2;

   typedef struct {
      logic [NI:0]      err;
      logic [47:0]      cap;
      logic             pass;
      logic [NI-1:0]    ff_row;
      logic [NO-1:0]    ff_bits;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   truth_table_checker_if #(.NUM_IN(NI), .NUM_OUT(NO)) bus ();

   truth_table_checker #(.NUM_IN(NI), .NUM_OUT(NO), .SETTLE(ST)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Breadboard block under test, output o on bit o.
   function automatic logic [NO-1:0] bb(input logic [NI-1:0] v);
      logic w, x, y, z, r1, r2, r3;
      w  = v[3]; x = v[2]; y = v[1]; z = v[0];
      r1 = x | (~y & z);
      r2 = ~(~x & ~(~y & z));
      r3 = (w & x & y & z) | (~w & ~x & ~y & ~z);
      return {r3, r2, r1};
   endfunction

   assign bus.resp_in = bb(bus.vec_out);

   // Expected sweep result for a given expected-mask load.
   function automatic exp_t model(input logic [47:0] m);
      exp_t e;
      logic [NO-1:0] r, x;
      logic seen;
      e.err = '0; e.cap = '0; e.ff_row = '0; e.ff_bits = '0; seen = 1'b0;
      for (int row = 0; row < ROWS; row++) begin
         r = bb(4'(row));
         for (int o = 0; o < NO; o++) begin
            e.cap[o*ROWS + row] = r[o];
            x[o] = r[o] ^ m[o*ROWS + row];
         end
         if (x != '0) begin
            e.err = e.err + 5'd1;
            if (!seen) begin
               seen = 1'b1;
               e.ff_row = 4'(row);
               e.ff_bits = x;
            end
         end
      end
      e.pass = (e.err == '0);
      return e;
   endfunction

   exp_t sbq[$];
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic launch(input string tag, input logic [47:0] m);
      bus.exp_mask = m;
      bus.start    = 1'b1;
      tick();
      bus.start    = 1'b0;
      check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
      check({tag, "_done_clr"},  64'(bus.done), 64'd0);
      check({tag, "_err_clr"},   64'(bus.err_count), 64'd0);
      sbq.push_back(model(m));
   endtask

   // Wait for done while checking the row stepping; optionally poke start and
   // scramble exp_mask at tick poke_at to show both are ignored while busy.
   task automatic run_sweep(input string tag, input int poke_at);
      int   k;
      logic ok;
      exp_t e;
      k  = 0;
      ok = 1'b1;
      while (!bus.done && k < LAT + 12) begin
         if (k == poke_at) begin
            bus.start    = 1'b1;
            bus.exp_mask = '0;
         end
         tick();
         k++;
         bus.start = 1'b0;
         if (bus.busy && bus.vec_out !== 4'(k / (ST + 1))) ok = 1'b0;
         if (!bus.busy && !bus.done) ok = 1'b0;
      end
      check({tag, "_latency"}, 64'(k), 64'(LAT));
      check({tag, "_vec_seq"}, 64'(ok), 64'd1);
      check({tag, "_busy_end"}, 64'(bus.busy), 64'd0);
      check({tag, "_sb_nonempty"}, 64'(sbq.size() > 0), 64'd1);
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         check({tag, "_err"},  64'(bus.err_count), 64'(e.err));
         check({tag, "_pass"}, 64'(bus.pass), 64'(e.pass));
         check({tag, "_cap"},  64'(bus.cap_mask), 64'(e.cap));
`ifdef FIRST_FAIL_EN
         check({tag, "_ff_row"},  64'(bus.first_fail_row), 64'(e.ff_row));
         check({tag, "_ff_bits"}, 64'(bus.first_fail_bits), 64'(e.ff_bits));
`endif
      end
   endtask

   initial begin
      int   n;
      logic hit;
      logic [47:0] rm;

      bus.start    = 1'b0;
      bus.exp_mask = '0;
      reset        = 1'b1;
      tick();
      tick();
      check("rst_vec",  64'(bus.vec_out), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_done", 64'(bus.done), 64'd0);
      check("rst_pass", 64'(bus.pass), 64'd0);
      check("rst_err",  64'(bus.err_count), 64'd0);
      check("rst_cap",  64'(bus.cap_mask), 64'd0);
      reset = 1'b0;
      tick();

      // Clean sweep against the correct masks.
      launch("clean", MASK_OK);
      run_sweep("clean", -1);
      check("clean_cap_const", 64'(bus.cap_mask), 64'(MASK_OK));
      check("clean_pass_const", 64'(bus.pass), 64'd1);

      // r3 row 0 flipped in the expected mask; restart from DONE.
      launch("r3flip", {16'h8000, 16'hF2F2, 16'hF2F2});
      run_sweep("r3flip", -1);
      check("r3flip_err_const", 64'(bus.err_count), 64'd1);
`ifdef FIRST_FAIL_EN
      check("r3flip_ffb_const", 64'(bus.first_fail_bits), 64'b100);
`endif

      // All-zero expectation: every row with any output high counts.
      launch("zeros", 48'h0);
      run_sweep("zeros", -1);
      check("zeros_err_const", 64'(bus.err_count), 64'd11);
      check("zeros_pass_const", 64'(bus.pass), 64'd0);

      // Start and exp_mask changes in the middle of a sweep are ignored.
      launch("poke", MASK_OK);
      run_sweep("poke", 10);

      // Arbitrary expectation load.
      rm = {16'($urandom), 32'($urandom)};
      launch("rand", rm);
      run_sweep("rand", -1);

      // Reset at row 7 aborts the sweep with nothing retained.
      launch("abort", MASK_OK);
      hit = 1'b0;
      n   = 0;
      while (!hit && n < 40) begin
         tick();
         n++;
         if (bus.vec_out == 4'd7) hit = 1'b1;
      end
      check("abort_reach_row7", 64'(hit), 64'd1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_vec",  64'(bus.vec_out), 64'd0);
      check("abort_busy", 64'(bus.busy), 64'd0);
      check("abort_done", 64'(bus.done), 64'd0);
      check("abort_pass", 64'(bus.pass), 64'd0);
      check("abort_err",  64'(bus.err_count), 64'd0);
      check("abort_cap",  64'(bus.cap_mask), 64'd0);
      tick();
      check("abort_idle_busy", 64'(bus.busy), 64'd0);
      check("abort_idle_done", 64'(bus.done), 64'd0);
      if (sbq.size() > 0) void'(sbq.pop_front());

      // Full clean sweep after the abort.
      launch("post_rst", MASK_OK);
      run_sweep("post_rst", -1);

      check("sb_drained", 64'(sbq.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
